// File: rtl/io_cfg_pkg.sv
// Shared config-chain types for the perimeter I/O tile.
// Per-channel field layout: bit0 dir (1 = input), bit1 out_inv.
package io_cfg_pkg;

   localparam int CFG_BITS    = 2;
   localparam int CFG_DIR     = 0;
   localparam int CFG_OUT_INV = 1;

   typedef struct packed {
      logic out_inv;
      logic dir;
   } cfg_t;

endpackage

// File: rtl/io_cfg_pad_ch.sv
// Combinational pad mux for one I/O channel, with isolation.
// Ports: i_en (not isolated and config valid), i_cfg (active field),
//   i_soc_in/o_soc_out/o_dir (pad ring), i_outpad/o_inpad (fabric).
module io_cfg_pad_ch
   import io_cfg_pkg::*;
#(
   parameter bit ISOL_DIR = 1'b1
) (
   input  logic i_en,
   input  cfg_t i_cfg,
   input  logic i_soc_in,
   input  logic i_outpad,
   output logic o_dir,
   output logic o_soc_out,
   output logic o_inpad
);

   always_comb begin
      o_dir     = ISOL_DIR;
      o_soc_out = 1'b0;
      o_inpad   = 1'b0;
      if (i_en) begin
         o_dir = i_cfg.dir;
         if (i_cfg.dir) begin
            o_inpad = i_soc_in;
         end else begin
            o_soc_out = i_outpad ^ i_cfg.out_inv;
         end
      end
   end

endmodule

// File: rtl/grid_io_cfg_chain_param.sv
// Perimeter I/O tile: NUM_IO pad channels behind a counted,
// double-buffered config chain (shadow shifts, commit -> active).
// Ports: prog_clk/prog_reset_n, IO_ISOL_N, ccff_head/ccff_en/ccff_tail,
//   cfg_commit/cfg_done/cfg_active, SoC pad IN/OUT/DIR, fabric outpad/inpad.
module grid_io_cfg_chain_param
   import io_cfg_pkg::*;
#(
   parameter int NUM_IO   = 9,
   parameter bit ISOL_DIR = 1'b1
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              IO_ISOL_N,
   input  logic              ccff_head,
   input  logic              ccff_en,
   input  logic              cfg_commit,
   input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
   output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
   output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
   input  logic [NUM_IO-1:0] fabric_outpad,
   output logic [NUM_IO-1:0] fabric_inpad,
   output logic              ccff_tail,
   output logic              cfg_done,
   output logic              cfg_active
);

   localparam int CHAIN_LEN = NUM_IO * CFG_BITS;
   localparam int CW        = $clog2(CHAIN_LEN + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CHAIN_LEN);

   logic [CHAIN_LEN-1:0] r_sh;
   cfg_t [NUM_IO-1:0]    r_act;
   logic [CW-1:0]        r_cnt;
   logic                 r_done;
   logic                 r_active;

   logic                 w_commit;
   logic [CW-1:0]        w_cnt_nxt;
   logic                 w_en;

   // A shift in the same cycle always wins over a commit.
   assign w_commit = cfg_commit & r_done & ~ccff_en;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (ccff_en) begin
         if (r_cnt != CNT_FULL) begin
            w_cnt_nxt = r_cnt + CW'(1);
         end
      end else if (w_commit) begin
         w_cnt_nxt = '0;
      end
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         r_sh     <= '0;
         r_act    <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_active <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_done <= (w_cnt_nxt == CNT_FULL);
         if (ccff_en) begin
            r_sh <= {r_sh[CHAIN_LEN-2:0], ccff_head};
         end else if (w_commit) begin
            r_act    <= r_sh;
            r_active <= 1'b1;
         end
      end
   end

   assign ccff_tail  = r_sh[CHAIN_LEN-1];
   assign cfg_done   = r_done;
   assign cfg_active = r_active;
   assign w_en       = IO_ISOL_N & r_active;

   for (genvar k = 0; k < NUM_IO; k++) begin : g_ch
      io_cfg_pad_ch #(
         .ISOL_DIR (ISOL_DIR)
      ) u_ch (
         .i_en      (w_en),
         .i_cfg     (r_act[k]),
         .i_soc_in  (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[k]),
         .i_outpad  (fabric_outpad[k]),
         .o_dir     (gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[k]),
         .o_soc_out (gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[k]),
         .o_inpad   (fabric_inpad[k])
      );
   end

endmodule

// File: tb/tb_grid_io_cfg_chain_param.sv
// Self-checking bench for grid_io_cfg_chain_param (NUM_IO=9).
// Reference model keeps shift history, a shift count and active config.
module tb_grid_io_cfg_chain_param;

   localparam int NIO = 9;
   localparam int CL  = 2 * NIO;
   localparam bit ISO = 1'b1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           iso_n;
   logic           head;
   logic           en;
   logic           commit;
   logic [NIO-1:0] soc_in;
   logic [NIO-1:0] soc_out;
   logic [NIO-1:0] soc_dir;
   logic [NIO-1:0] outpad;
   logic [NIO-1:0] inpad;
   logic           tail;
   logic           done;
   logic           active;

   int ntests = 0;
   int nfail  = 0;

   bit             m_hist[$];
   int             m_cnt;
   bit             m_active;
   logic [NIO-1:0] m_dir;
   logic [NIO-1:0] m_inv;

   always #5 clk = ~clk;

   grid_io_cfg_chain_param #(
      .NUM_IO   (NIO),
      .ISOL_DIR (ISO)
   ) dut (
      .prog_clk                         (clk),
      .prog_reset_n                     (rst_n),
      .IO_ISOL_N                        (iso_n),
      .ccff_head                        (head),
      .ccff_en                          (en),
      .cfg_commit                       (commit),
      .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (soc_in),
      .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (soc_out),
      .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (soc_dir),
      .fabric_outpad                    (outpad),
      .fabric_inpad                     (inpad),
      .ccff_tail                        (tail),
      .cfg_done                         (done),
      .cfg_active                       (active)
   );

   // bit i of the shadow chain is the bit shifted in i shifts ago
   function automatic bit sh_at(int i);
      if (i < m_hist.size()) return m_hist[m_hist.size() - 1 - i];
      return 1'b0;
   endfunction

   function automatic logic [NIO-1:0] e_dir();
      logic [NIO-1:0] r;
      for (int k = 0; k < NIO; k++)
         r[k] = (iso_n && m_active) ? m_dir[k] : ISO;
      return r;
   endfunction

   function automatic logic [NIO-1:0] e_out();
      logic [NIO-1:0] r;
      for (int k = 0; k < NIO; k++)
         r[k] = (iso_n && m_active && !m_dir[k]) ?
                (outpad[k] ^ m_inv[k]) : 1'b0;
      return r;
   endfunction

   function automatic logic [NIO-1:0] e_inp();
      logic [NIO-1:0] r;
      for (int k = 0; k < NIO; k++)
         r[k] = (iso_n && m_active && m_dir[k]) ? soc_in[k] : 1'b0;
      return r;
   endfunction

   task automatic m_reset();
      m_hist.delete();
      m_cnt    = 0;
      m_active = 0;
      m_dir    = '0;
      m_inv    = '0;
   endtask

   // called at a negedge; returns at the following negedge
   task automatic step(input logic e, input logic h, input logic c);
      en     = e;
      head   = h;
      commit = c;
      @(posedge clk);
      if (e) begin
         m_hist.push_back(h);
         if (m_hist.size() > CL) void'(m_hist.pop_front());
         if (m_cnt < CL) m_cnt++;
      end else if (c && m_cnt == CL) begin
         for (int k = 0; k < NIO; k++) begin
            m_dir[k] = sh_at(2 * k);
            m_inv[k] = sh_at(2 * k + 1);
         end
         m_active = 1;
         m_cnt    = 0;
      end
      @(negedge clk);
      en     = 1'b0;
      commit = 1'b0;
   endtask

   // shifts img MSB first so that the chain ends up holding img
   task automatic load(input logic [CL-1:0] img);
      for (int i = CL - 1; i >= 0; i--) step(1'b1, img[i], 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      m_reset();
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      ntests++;
      if (soc_dir !== 9'h1FF) begin
         $display("FAIL reset_dir: got %h exp %h", soc_dir, 9'h1FF);
         nfail++;
      end
      ntests++;
      if (soc_out !== 9'h000 || inpad !== 9'h000) begin
         $display("FAIL reset_data: out %h inpad %h exp 0", soc_out, inpad);
         nfail++;
      end
      ntests++;
      if (done !== 1'b0 || tail !== 1'b0 || active !== 1'b0) begin
         $display("FAIL reset_flags: done %b tail %b active %b exp 0",
                  done, tail, active);
         nfail++;
      end
   endtask

   task automatic test_bad_commit();
      for (int i = 0; i < CL - 1; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      ntests++;
      if (active !== 1'b0 || done !== 1'b0) begin
         $display("FAIL short_commit: active %b done %b exp 0 0",
                  active, done);
         nfail++;
      end
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      ntests++;
      if (active !== 1'b0 || done !== 1'b1) begin
         $display("FAIL commit_during_shift: active %b done %b exp 0 1",
                  active, done);
         nfail++;
      end
   endtask

   task automatic test_load_commit();
      logic [CL-1:0] img;
      do_reset();
      img = {{(NIO - 1){2'b01}}, 2'b10};
      outpad = '0;
      soc_in = 9'h020;
      iso_n  = 1'b1;
      for (int i = CL - 1; i >= 1; i--) step(1'b1, img[i], 1'b0);
      ntests++;
      if (done !== 1'b0) begin
         $display("FAIL done_at_17: got %b exp 0", done);
         nfail++;
      end
      step(1'b1, img[0], 1'b0);
      ntests++;
      if (done !== 1'b1 || tail !== img[CL-1]) begin
         $display("FAIL done_at_18: done %b tail %b exp 1 %b",
                  done, tail, img[CL-1]);
         nfail++;
      end
      step(1'b0, 1'b0, 1'b1);
      #1;
      ntests++;
      if (soc_out[0] !== 1'b1 || soc_dir[0] !== 1'b0) begin
         $display("FAIL ch0_cfg: out %b dir %b exp 1 0",
                  soc_out[0], soc_dir[0]);
         nfail++;
      end
      ntests++;
      if (inpad[5] !== 1'b1 || soc_dir !== 9'h1FE) begin
         $display("FAIL ch5_in: inpad %h dir %h exp bit5=1 1fe",
                  inpad, soc_dir);
         nfail++;
      end
      ntests++;
      if (active !== 1'b1 || done !== 1'b0) begin
         $display("FAIL after_commit: active %b done %b exp 1 0",
                  active, done);
         nfail++;
      end
   endtask

   task automatic test_reprogram();
      logic [CL-1:0] img;
      logic [NIO-1:0] old_dir;
      logic [NIO-1:0] old_out;
      img     = CL'($urandom);
      outpad  = NIO'($urandom);
      soc_in  = NIO'($urandom);
      #1;
      old_dir = soc_dir;
      old_out = soc_out;
      for (int i = CL - 1; i >= 0; i--) begin
         step(1'b1, img[i], 1'b0);
         ntests++;
         if (soc_dir !== old_dir || soc_out !== old_out ||
             tail !== sh_at(CL - 1)) begin
            $display("FAIL reprog_hold: dir %h out %h tail %b exp %h %h %b",
                     soc_dir, old_out, tail, old_dir, old_out, sh_at(CL - 1));
            nfail++;
         end
      end
      ntests++;
      if (tail !== img[CL-1]) begin
         $display("FAIL reprog_tail: got %b exp %b", tail, img[CL-1]);
         nfail++;
      end
      step(1'b0, 1'b0, 1'b1);
      ntests++;
      if (soc_dir !== e_dir() || soc_out !== e_out() ||
          inpad !== e_inp()) begin
         $display("FAIL reprog_apply: dir %h out %h in %h exp %h %h %h",
                  soc_dir, soc_out, inpad, e_dir(), e_out(), e_inp());
         nfail++;
      end
   endtask

   task automatic test_isolation();
      iso_n = 1'b0;
      #1;
      ntests++;
      if (soc_dir !== 9'h1FF || soc_out !== '0 || inpad !== '0) begin
         $display("FAIL isolate: dir %h out %h in %h exp 1ff 0 0",
                  soc_dir, soc_out, inpad);
         nfail++;
      end
      iso_n = 1'b1;
      #1;
      ntests++;
      if (soc_dir !== e_dir() || soc_out !== e_out() ||
          inpad !== e_inp()) begin
         $display("FAIL unisolate: dir %h out %h in %h exp %h %h %h",
                  soc_dir, soc_out, inpad, e_dir(), e_out(), e_inp());
         nfail++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midshift();
      logic [CL-1:0] img;
      for (int i = 0; i < 10; i++) step(1'b1, 1'(i), 1'b0);
      en = 1'b1;
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      ntests++;
      if (active !== 1'b0 || done !== 1'b0 || soc_dir !== 9'h1FF ||
          tail !== 1'b0) begin
         $display("FAIL async_reset: active %b done %b dir %h tail %b",
                  active, done, soc_dir, tail);
         nfail++;
      end
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      img = CL'($urandom);
      for (int i = CL - 1; i >= 1; i--) step(1'b1, img[i], 1'b0);
      ntests++;
      if (done !== 1'b0) begin
         $display("FAIL cnt_cleared: done %b exp 0", done);
         nfail++;
      end
      step(1'b1, img[0], 1'b0);
      step(1'b0, 1'b0, 1'b1);
      ntests++;
      if (active !== 1'b1 || soc_dir !== e_dir() || soc_out !== e_out()) begin
         $display("FAIL reload: active %b dir %h out %h exp 1 %h %h",
                  active, soc_dir, soc_out, e_dir(), e_out());
         nfail++;
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         iso_n  = ($urandom_range(0, 99) < 85);
         soc_in = NIO'($urandom);
         outpad = NIO'($urandom);
         step($urandom_range(0, 99) < 70, 1'($urandom),
              $urandom_range(0, 99) < 40);
         ntests++;
         if (soc_dir !== e_dir() || soc_out !== e_out() ||
             inpad !== e_inp()) begin
            $display("FAIL rand_pads[%0d]: dir %h out %h in %h exp %h %h %h",
                     n, soc_dir, soc_out, inpad, e_dir(), e_out(), e_inp());
            nfail++;
         end
         ntests++;
         if (done !== (m_cnt == CL) || active !== m_active ||
             tail !== sh_at(CL - 1)) begin
            $display("FAIL rand_flags[%0d]: done %b act %b tail %b exp %b %b %b",
                     n, done, active, tail, (m_cnt == CL), m_active,
                     sh_at(CL - 1));
            nfail++;
         end
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      iso_n  = 1'b1;
      head   = 1'b0;
      en     = 1'b0;
      commit = 1'b0;
      soc_in = '0;
      outpad = '0;
      m_reset();
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_bad_commit();
      test_load_commit();
      test_reprogram();
      test_isolation();
      test_reset_midshift();
      test_random();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
